// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the datapath `isr` input.
// Holds the PC and issues one outstanding word read at a time over a
// req/ack handshake that may take any number of cycles. Fetched words go
// into a small prefetch queue that the datapath pops once per cycle. A
// redirect flushes the queue and restarts fetch at the target. If a read
// is still in flight at that moment, its ack is discarded when it arrives.
// Optional feature macro: FETCH_PERF_CNT_EN adds the saturating counters
// stall_cnt, flush_cnt and drop_cnt.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [PC_W-1:0]           imem_addr,
    input  logic                      imem_ack,
    input  logic [15:0]               imem_data,
    input  logic                      stl,
    input  logic                      redirect,
    input  logic [PC_W-1:0]           target,
    output logic [15:0]               isr,
    output logic                      isr_valid,
    output logic [$clog2(QDEPTH):0]   q_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               flush_cnt,
    output logic [15:0]               drop_cnt
`endif
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    logic [PC_W-1:0]   pc_r;
    logic              drop_r;
    logic [AW-1:0]     head_r;
    logic [AW-1:0]     tail_r;
    logic [CW-1:0]     count_r;
    logic [15:0]       mem_r [QDEPTH];

    logic              q_empty_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;

    // Only one request is ever in flight, so in IDLE the room check is count alone.
    assign q_empty_s = (count_r == {CW{1'b0}});
    assign pop_s     = !stl && !q_empty_s && !redirect;
    assign push_s    = (state_r == S_WAIT) && imem_ack && !drop_r && !redirect;
    assign issue_s   = (state_r == S_IDLE) && !redirect && (count_r < CW'(QDEPTH));

    assign isr_valid = !q_empty_s && !redirect;
    assign q_count   = count_r;

    // Head of queue straight to the datapath, NOP whenever nothing valid is offered.
    always_comb begin
        isr = 16'h0000;
        if (isr_valid) begin
            isr = mem_r[head_r];
        end else begin
            isr = 16'h0000;
        end
    end

    // Request FSM: issue, wait for ack, discard acks of requests orphaned by a redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            drop_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (issue_s) begin
                        state_r   <= S_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_r;
                    end else begin
                        state_r   <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        state_r  <= S_IDLE;
                        imem_req <= 1'b0;
                        drop_r   <= 1'b0;
                    end else if (redirect) begin
                        drop_r   <= 1'b1;
                    end else begin
                        drop_r   <= drop_r;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    imem_req <= 1'b0;
                    drop_r   <= 1'b0;
                end
            endcase
        end
    end

    // Program counter: redirect target wins, otherwise advance on each kept word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else if (redirect) begin
            pc_r <= target;
        end else if (push_s) begin
            pc_r <= pc_r + PC_W'(1'b1);
        end else begin
            pc_r <= pc_r;
        end
    end

    // Prefetch queue: circular buffer with flush on redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else if (redirect) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[tail_r] <= imem_data;
                tail_r        <= tail_r + AW'(1'b1);
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt_s;
    logic drop_evt_s;

    assign stall_evt_s = stl && !q_empty_s;
    assign drop_evt_s  = (state_r == S_WAIT) && imem_ack && (drop_r || redirect);

    // Saturating event counters for stall cycles, flushes and discarded acks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
            drop_cnt  <= 16'h0000;
        end else begin
            if (stall_evt_s && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            else stall_cnt <= stall_cnt;
            if (redirect && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
            else flush_cnt <= flush_cnt;
            if (drop_evt_s && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            else drop_cnt <= drop_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle table for the start-up stream,
// plus a scoreboard of expected isr words and request addresses for the
// stall, redirect and reset sequences. A second instance with RESET_PC=FE
// runs in lockstep to observe PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_req_fe;
    logic [7:0]  imem_addr, imem_addr_fe;
    logic        imem_ack;
    logic [15:0] imem_data, imem_data_fe;
    logic        stl, redirect;
    logic [7:0]  target;
    logic [15:0] isr, isr_fe;
    logic        isr_valid, isr_valid_fe;
    logic [2:0]  q_count, q_count_fe;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt, drop_cnt;
    logic [15:0] stall_cnt_fe, flush_cnt_fe, drop_cnt_fe;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 0;
    int wait_cnt = 0;
    logic mon_en = 1'b0;
    logic req_q  = 1'b0;
    logic [15:0] exp_isr[$];
    logic [7:0]  exp_addr[$];

    fetch_unit #(.PC_W(8), .QDEPTH(4), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .stl(stl), .redirect(redirect),
        .target(target), .isr(isr), .isr_valid(isr_valid), .q_count(q_count)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .drop_cnt(drop_cnt)
`endif
    );

    fetch_unit #(.PC_W(8), .QDEPTH(4), .RESET_PC(8'hFE)) u_dut_fe (
        .clk(clk), .reset(reset), .imem_req(imem_req_fe), .imem_addr(imem_addr_fe),
        .imem_ack(imem_ack), .imem_data(imem_data_fe), .stl(stl), .redirect(redirect),
        .target(target), .isr(isr_fe), .isr_valid(isr_valid_fe), .q_count(q_count_fe)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cnt(stall_cnt_fe), .flush_cnt(flush_cnt_fe), .drop_cnt(drop_cnt_fe)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: acks mem_lat cycles after the request is seen, data = A000 + addr.
    initial begin
        imem_ack = 1'b0;
        imem_data = 16'h0000;
        imem_data_fe = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (imem_req && reset) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack     = 1'b1;
                    imem_data    = 16'hA000 + {8'h00, imem_addr};
                    imem_data_fe = 16'hA000 + {8'h00, imem_addr_fe};
                    wait_cnt     = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: pops expected words on each datapath pop and
    // expected addresses on each new request.
    always @(negedge clk) begin
        logic [15:0] ew;
        logic [7:0]  ea;
        if (mon_en && reset) begin
            if (isr_valid && !stl && exp_isr.size() > 0) begin
                ew = exp_isr.pop_front();
                chk("sb_isr", {16'h0, isr}, {16'h0, ew});
            end
            if (imem_req && !req_q && exp_addr.size() > 0) begin
                ea = exp_addr.pop_front();
                chk("sb_addr", {24'h0, imem_addr}, {24'h0, ea});
            end
            if (imem_req && imem_ack) begin
                chk("no_push_full", {31'h0, q_count < 3'd4}, 32'd1);
            end
        end
        req_q = imem_req;
    end

    typedef struct {
        logic        stl;
        logic        req;
        logic [7:0]  addr;
        logic [7:0]  addr_fe;
        logic        valid;
        logic [15:0] isr;
        logic [2:0]  qc;
    } vec_t;

    vec_t vecs[8];

    task automatic start_phase(input int lat, input logic stl_v);
        reset = 1'b0;
        mon_en = 1'b0;
        stl = stl_v;
        redirect = 1'b0;
        target = 8'h00;
        mem_lat = lat;
        exp_isr.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bit found;
        stl = 1'b0; redirect = 1'b0; target = 8'h00;

        vecs[0] = '{1'b0, 1'b1, 8'h00, 8'hFE, 1'b0, 16'h0000, 3'd0};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'hFE, 1'b1, 16'hA000, 3'd1};
        vecs[2] = '{1'b0, 1'b1, 8'h01, 8'hFF, 1'b0, 16'h0000, 3'd0};
        vecs[3] = '{1'b0, 1'b0, 8'h01, 8'hFF, 1'b1, 16'hA001, 3'd1};
        vecs[4] = '{1'b0, 1'b1, 8'h02, 8'h00, 1'b0, 16'h0000, 3'd0};
        vecs[5] = '{1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 16'hA002, 3'd1};
        vecs[6] = '{1'b0, 1'b1, 8'h03, 8'h01, 1'b0, 16'h0000, 3'd0};
        vecs[7] = '{1'b0, 1'b0, 8'h03, 8'h01, 1'b1, 16'hA003, 3'd1};

        // Reset values without any clock edge.
        #2;
        reset = 1'b0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h00);
        chk("rst_addr_fe", {24'h0, imem_addr_fe}, 32'hFE);
        chk("rst_isr", {16'h0, isr}, 32'h0);
        chk("rst_valid", {31'h0, isr_valid}, 32'd0);
        chk("rst_qc", {29'h0, q_count}, 32'd0);

        // Start-up stream with single-cycle memory, cycle by cycle.
        start_phase(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            stl = vecs[i].stl;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
            chk($sformatf("tbl%0d_addr", i), {24'h0, imem_addr}, {24'h0, vecs[i].addr});
            chk($sformatf("tbl%0d_addr_fe", i), {24'h0, imem_addr_fe}, {24'h0, vecs[i].addr_fe});
            chk($sformatf("tbl%0d_valid", i), {31'h0, isr_valid}, {31'h0, vecs[i].valid});
            chk($sformatf("tbl%0d_isr", i), {16'h0, isr}, {16'h0, vecs[i].isr});
            chk($sformatf("tbl%0d_qc", i), {29'h0, q_count}, {29'h0, vecs[i].qc});
        end

        // Stall for 20 cycles: queue fills, requests stop, head is held.
        start_phase(0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            exp_isr.push_back(16'hA000 + 16'(i));
            exp_addr.push_back(8'(i));
        end
        mon_en = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_qc", {29'h0, q_count}, 32'd4);
        chk("stall_req", {31'h0, imem_req}, 32'd0);
        chk("stall_isr", {16'h0, isr}, 32'hA000);
        @(posedge clk);
        #1;
        stl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_valid", i), {31'h0, isr_valid}, 32'd1);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_sb_isr_left", exp_isr.size(), 32'd0);
        chk("stall_sb_addr_left", exp_addr.size(), 32'd0);

        // Redirect to 0x40 while the read of 0x03 waits on a slow memory.
        start_phase(3, 1'b0);
        exp_isr = '{16'hA000, 16'hA001, 16'hA002, 16'hA040, 16'hA041};
        exp_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h41};
        mon_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (imem_req && imem_addr == 8'h03) found = 1'b1;
        end
        chk("wait_addr3_found", {31'h0, found}, 32'd1);
        redirect = 1'b1;
        target = 8'h40;
        @(negedge clk);
        chk("redir_isr_zero", {16'h0, isr}, 32'h0);
        chk("redir_valid_zero", {31'h0, isr_valid}, 32'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_req_held", {31'h0, imem_req}, 32'd1);
        chk("redir_addr_held", {24'h0, imem_addr}, 32'h03);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("redir_sb_isr_left", exp_isr.size(), 32'd0);
        chk("redir_sb_addr_left", exp_addr.size(), 32'd0);

        // Redirect coinciding with an ack and a pop on a non-empty queue.
        start_phase(0, 1'b1);
        exp_isr = '{16'hA020, 16'hA021};
        exp_addr = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h21};
        mon_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (imem_req && q_count == 3'd2) found = 1'b1;
        end
        chk("wait_q2_found", {31'h0, found}, 32'd1);
        stl = 1'b0;
        redirect = 1'b1;
        target = 8'h20;
        @(negedge clk);
        chk("coinc_ack_seen", {31'h0, imem_ack}, 32'd1);
        chk("coinc_isr_zero", {16'h0, isr}, 32'h0);
        chk("coinc_valid_zero", {31'h0, isr_valid}, 32'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("coinc_qc", {29'h0, q_count}, 32'd0);
        chk("coinc_req", {31'h0, imem_req}, 32'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("coinc_sb_isr_left", exp_isr.size(), 32'd0);
        chk("coinc_sb_addr_left", exp_addr.size(), 32'd0);

        // Asynchronous reset mid-request with two words queued.
        start_phase(0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (imem_req && q_count == 3'd2) found = 1'b1;
        end
        chk("wait_mid_found", {31'h0, found}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'd0);
        chk("mid_rst_addr", {24'h0, imem_addr}, 32'h00);
        chk("mid_rst_addr_fe", {24'h0, imem_addr_fe}, 32'hFE);
        chk("mid_rst_isr", {16'h0, isr}, 32'h0);
        chk("mid_rst_valid", {31'h0, isr_valid}, 32'd0);
        chk("mid_rst_qc", {29'h0, q_count}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_rst_stall_cnt", {16'h0, stall_cnt}, 32'd0);
        chk("mid_rst_flush_cnt", {16'h0, flush_cnt}, 32'd0);
        chk("mid_rst_drop_cnt", {16'h0, drop_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
